// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Write-side controller for the clock's hour/minute/second counters. In RUN
//   it is idle. A mode press copies the live time into edit registers. Each
//   field can then be stepped up or down with wrap-around. After the seconds
//   field, a final mode press commits the edit with one load strobe per
//   counter (hour, then minute, then second). An edit session with no button
//   press for TIMEOUT cycles is dropped and nothing is loaded.
//
// Ports
//   clk        system clock, all logic on posedge
//   clear_n    synchronous active-low reset
//   btn_mode   synchronised level; rising edge selects the next field / commits
//   btn_inc    synchronised level; rising edge adds one to the selected field
//   btn_dec    synchronised level; rising edge subtracts one from the field
//   cur_sec    live seconds value, 0..59
//   cur_min    live minutes value, 0..59
//   cur_hour   live hours value, 0..HOUR_MAX
//   data       value driven to the counters' parallel-load inputs
//   load_sec   one-cycle load strobe for the seconds counter
//   load_min   one-cycle load strobe for the minutes counter
//   load_hour  one-cycle load strobe for the hours counter
//   setting    high while editing or committing; freezes the counters
//   field_sel  field being edited: 0 none, 1 hour, 2 minute, 3 second
// ---------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int unsigned         HOUR_MAX = 23,
  parameter int unsigned         TO_W     = 32,
  parameter logic [TO_W-1:0]     TIMEOUT  = 32'd300
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_hour,
  output logic [5:0] data,
  output logic       load_sec,
  output logic       load_min,
  output logic       load_hour,
  output logic       setting,
  output logic [1:0] field_sel
);

  localparam logic [5:0] HMAX = 6'(HOUR_MAX);
  localparam logic [5:0] MS_MAX = 6'd59;

  typedef enum logic [2:0] {
    RUN,
    EDIT_H,
    EDIT_M,
    EDIT_S,
    COMMIT_H,
    COMMIT_M,
    COMMIT_S
  } state_t;

  state_t          state;
  logic [5:0]      e_h, e_m, e_s;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            mode_q, inc_q, dec_q;
  // Low for the first cycle after reset so a button held through reset is
  // not seen as a fresh press when the history register still reads 0.
  logic            armed;
  logic            mode_p, inc_p, dec_p;

  assign mode_p     = armed & btn_mode & ~mode_q;
  assign inc_p      = armed & btn_inc  & ~inc_q;
  assign dec_p      = armed & btn_dec  & ~dec_q;
  assign to_cnt_nxt = to_cnt + 1'b1;

  // One step up or down with wrap between 0 and top.
  function automatic logic [5:0] step(input logic [5:0] v,
                                      input logic [5:0] top,
                                      input logic       up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // NOTE: all state in a clocked block uses <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state  <= RUN;
      e_h    <= '0;
      e_m    <= '0;
      e_s    <= '0;
      to_cnt <= '0;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      armed  <= 1'b1;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      dec_q  <= btn_dec;

      case (state)
        RUN: begin
          to_cnt <= '0;
          if (mode_p) begin
            state <= EDIT_H;
            e_h   <= cur_hour;
            e_m   <= cur_min;
            e_s   <= cur_sec;
          end
        end

        EDIT_H, EDIT_M, EDIT_S: begin
          // Any press restarts the inactivity window; otherwise count and
          // abandon the edit once the window is used up.
          if (mode_p || inc_p || dec_p) begin
            to_cnt <= '0;
          end else if (to_cnt_nxt == TIMEOUT) begin
            to_cnt <= '0;
            state  <= RUN;
          end else begin
            to_cnt <= to_cnt_nxt;
          end

          // Mode has priority over inc/dec; inc together with dec cancels.
          if (mode_p) begin
            case (state)
              EDIT_H:  state <= EDIT_M;
              EDIT_M:  state <= EDIT_S;
              default: state <= COMMIT_H;
            endcase
          end else if (inc_p ^ dec_p) begin
            case (state)
              EDIT_H:  e_h <= step(e_h, HMAX, inc_p);
              EDIT_M:  e_m <= step(e_m, MS_MAX, inc_p);
              default: e_s <= step(e_s, MS_MAX, inc_p);
            endcase
          end
        end

        COMMIT_H: state <= COMMIT_M;
        COMMIT_M: state <= COMMIT_S;
        COMMIT_S: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Outputs decode the state directly, so only one load can ever be high and
  // a reset removes every strobe on the very next cycle.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    data      = '0;
    load_sec  = 1'b0;
    load_min  = 1'b0;
    load_hour = 1'b0;
    setting   = 1'b0;
    field_sel = 2'd0;
    case (state)
      EDIT_H: begin
        setting   = 1'b1;
        field_sel = 2'd1;
      end
      EDIT_M: begin
        setting   = 1'b1;
        field_sel = 2'd2;
      end
      EDIT_S: begin
        setting   = 1'b1;
        field_sel = 2'd3;
      end
      COMMIT_H: begin
        setting   = 1'b1;
        load_hour = 1'b1;
        data      = e_h;
      end
      COMMIT_M: begin
        setting   = 1'b1;
        load_min  = 1'b1;
        data      = e_m;
      end
      COMMIT_S: begin
        setting   = 1'b1;
        load_sec  = 1'b1;
        data      = e_s;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//   Self-checking bench for time_set_ctrl: a directed vector table, a few
//   hand-written multi-cycle sequences (wrap, simultaneous presses, timeout,
//   reset during commit) and a randomized run. A behavioural model of the
//   time-setting rules predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int HOUR_MAX = 23;
  localparam int TIMEOUT  = 300;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       btn_mode, btn_inc, btn_dec;
  logic [5:0] cur_sec, cur_min, cur_hour;
  logic [5:0] data;
  logic       load_sec, load_min, load_hour, setting;
  logic [1:0] field_sel;

  time_set_ctrl #(
    .HOUR_MAX (HOUR_MAX),
    .TO_W     (32),
    .TIMEOUT  (32'(TIMEOUT))
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .cur_sec   (cur_sec),
    .cur_min   (cur_min),
    .cur_hour  (cur_hour),
    .data      (data),
    .load_sec  (load_sec),
    .load_min  (load_min),
    .load_hour (load_hour),
    .setting   (setting),
    .field_sel (field_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model. phase: 0 = running, 1..3 = editing field phase-1
  // (hour, minute, second), 4..6 = writing field phase-4 back.
  // ------------------------------------------------------------------------
  int m_phase;
  int m_idle;
  int m_f[3];
  bit m_fresh;   // first cycle after reset: presses are not recognised
  bit m_prev[3];

  function automatic int fmax(input int k);
    return (k == 0) ? HOUR_MAX : 59;
  endfunction

  task automatic model_step();
    bit pm, pi, pd;
    int k, modn;
    if (!clear_n) begin
      m_phase = 0;
      m_idle  = 0;
      m_f     = '{0, 0, 0};
      m_prev  = '{0, 0, 0};
      m_fresh = 1'b1;
      return;
    end
    pm = !m_fresh && btn_mode && !m_prev[0];
    pi = !m_fresh && btn_inc  && !m_prev[1];
    pd = !m_fresh && btn_dec  && !m_prev[2];
    m_fresh = 1'b0;
    m_prev  = '{btn_mode, btn_inc, btn_dec};

    if (m_phase == 0) begin
      if (pm) begin
        m_phase = 1;
        m_idle  = 0;
        m_f     = '{int'(cur_hour), int'(cur_min), int'(cur_sec)};
      end
    end else if (m_phase <= 3) begin
      if (pm || pi || pd) begin
        m_idle = 0;
        if (pm) begin
          m_phase++;
        end else if (pi != pd) begin
          k    = m_phase - 1;
          modn = fmax(k) + 1;
          m_f[k] = pi ? (m_f[k] + 1) % modn : (m_f[k] + modn - 1) % modn;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_phase = 0;
          m_idle  = 0;
        end
      end
    end else begin
      m_phase = (m_phase == 6) ? 0 : m_phase + 1;
    end
  endtask

  task automatic compare_model();
    int exp_data;
    exp_data = (m_phase >= 4) ? m_f[m_phase-4] : 0;
    check("setting",   setting,   int'(m_phase != 0));
    check("field_sel", field_sel, (m_phase >= 1 && m_phase <= 3) ? m_phase : 0);
    check("load_hour", load_hour, int'(m_phase == 4));
    check("load_min",  load_min,  int'(m_phase == 5));
    check("load_sec",  load_sec,  int'(m_phase == 6));
    check("data",      data,      exp_data);
    check("one_load",  int'(load_hour) + int'(load_min) + int'(load_sec) <= 1, 1);
  endtask

  // One clock: inputs are already stable; model and DUT see the same edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    cycle();
    btn_mode = 0; btn_inc = 0; btn_dec = 0;
    cycle();
  endtask

  task automatic do_reset();
    clear_n = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0;
    cycle();
    clear_n = 1;
    cycle();
  endtask

  // Final mode press from EDIT_S, then the three write-back cycles.
  task automatic commit_check(input string tag, input int h, input int m, input int s);
    btn_mode = 1;
    cycle();
    btn_mode = 0;
    check({tag, "_ld_hour"}, load_hour, 1);
    check({tag, "_hour"},    data,      h);
    cycle();
    check({tag, "_ld_min"},  load_min,  1);
    check({tag, "_min"},     data,      m);
    cycle();
    check({tag, "_ld_sec"},  load_sec,  1);
    check({tag, "_sec"},     data,      s);
    cycle();
    check({tag, "_setting"}, setting,   0);
  endtask

  // ------------------------------------------------------------------------
  // Directed vector table
  // ------------------------------------------------------------------------
  typedef struct {
    bit clr_n, mode, inc, dec;
    bit e_set;
    int e_fsel;
    bit e_lh, e_lm, e_ls;
    int e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit c, bit m, bit i, bit d, bit st, int fs,
                              bit lh, bit lm, bit ls, int dt);
    vec_t v;
    v.clr_n = c; v.mode = m; v.inc = i; v.dec = d;
    v.e_set = st; v.e_fsel = fs; v.e_lh = lh; v.e_lm = lm; v.e_ls = ls;
    v.e_data = dt;
    return v;
  endfunction

  initial begin
    clear_n  = 0;
    btn_mode = 1; btn_inc = 1; btn_dec = 1;
    cur_hour = 6'd12; cur_min = 6'd34; cur_sec = 6'd56;

    // Reset with buttons held, release, then 12:34:56 -> 14:33:56.
    vecs.push_back(mk(0,1,1,1, 0,0,0,0,0, 0));
    vecs.push_back(mk(1,1,1,1, 0,0,0,0,0, 0));  // held through reset: no press
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 1,1,0,0,0, 0));  // enter hour edit
    vecs.push_back(mk(1,0,0,0, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,0,1,0, 1,1,0,0,0, 0));  // 13
    vecs.push_back(mk(1,0,0,0, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,0,1,0, 1,1,0,0,0, 0));  // 14
    vecs.push_back(mk(1,0,0,0, 1,1,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 1,2,0,0,0, 0));  // minute edit
    vecs.push_back(mk(1,0,0,0, 1,2,0,0,0, 0));
    vecs.push_back(mk(1,0,0,1, 1,2,0,0,0, 0));  // 33
    vecs.push_back(mk(1,0,0,0, 1,2,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 1,3,0,0,0, 0));  // second edit
    vecs.push_back(mk(1,0,0,0, 1,3,0,0,0, 0));
    vecs.push_back(mk(1,1,0,0, 1,0,1,0,0, 14)); // commit hour
    vecs.push_back(mk(1,0,0,0, 1,0,0,1,0, 33)); // commit minute
    vecs.push_back(mk(1,1,0,0, 1,0,0,0,1, 56)); // mode during commit ignored
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,0, 0));  // back to run
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0));
    vecs.push_back(mk(1,0,1,0, 0,0,0,0,0, 0));  // inc in run ignored
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      clear_n  = vecs[n].clr_n;
      btn_mode = vecs[n].mode;
      btn_inc  = vecs[n].inc;
      btn_dec  = vecs[n].dec;
      cycle();
      check($sformatf("vec%0d_setting", n),   setting,   int'(vecs[n].e_set));
      check($sformatf("vec%0d_field_sel", n), field_sel, vecs[n].e_fsel);
      check($sformatf("vec%0d_load_hour", n), load_hour, int'(vecs[n].e_lh));
      check($sformatf("vec%0d_load_min", n),  load_min,  int'(vecs[n].e_lm));
      check($sformatf("vec%0d_load_sec", n),  load_sec,  int'(vecs[n].e_ls));
      check($sformatf("vec%0d_data", n),      data,      vecs[n].e_data);
    end

    // Wrap at every boundary: 23:00:59 -> 0:59:0.
    do_reset();
    cur_hour = 6'(HOUR_MAX); cur_min = 6'd0; cur_sec = 6'd59;
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    commit_check("wrap", 0, 59, 0);

    // Hour 0 dec and minute 59 inc wrap the other way: 0:59:0 -> 23:0:0.
    cur_hour = 6'd0; cur_min = 6'd59; cur_sec = 6'd0;
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    commit_check("wrap2", HOUR_MAX, 0, 0);

    // Simultaneous presses: mode beats inc, inc+dec cancel.
    cur_hour = 6'd5; cur_min = 6'd10; cur_sec = 6'd20;
    press(1, 0, 0);
    btn_mode = 1; btn_inc = 1;
    cycle();
    check("mode_inc_field", field_sel, 2);
    btn_mode = 0; btn_inc = 0;
    cycle();
    press(0, 1, 1);
    check("inc_dec_field", field_sel, 2);
    press(1, 0, 0);
    commit_check("simul", 5, 10, 20);

    // Inactivity timeout from hour edit.
    begin
      int n;
      n = 0;
      btn_mode = 1;
      cycle();
      btn_mode = 0;
      check("to_entered", setting, 1);
      while (setting && n < 2 * TIMEOUT) begin
        cycle();
        n++;
        check("to_no_load", int'(load_hour | load_min | load_sec), 0);
      end
      check("to_cycles", n, TIMEOUT);
      check("to_setting", setting, 0);
    end

    // Reset during the minute write-back.
    cur_hour = 6'd1; cur_min = 6'd2; cur_sec = 6'd3;
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    btn_mode = 1;
    cycle();
    btn_mode = 0;
    check("rst_ld_hour", load_hour, 1);
    cycle();
    check("rst_ld_min", load_min, 1);
    clear_n = 0;
    cycle();
    check("rst_loads", int'(load_hour | load_min | load_sec), 0);
    check("rst_setting", setting, 0);
    clear_n = 1;
    for (int n = 0; n < 4; n++) begin
      cycle();
      check("rst_no_sec", load_sec, 0);
    end

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      clear_n  = ($urandom_range(0, 299) != 0);
      btn_mode = ($urandom_range(0, 3) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
      btn_dec  = ($urandom_range(0, 2) == 0);
      cur_hour = 6'($urandom_range(0, HOUR_MAX));
      cur_min  = 6'($urandom_range(0, 59));
      cur_sec  = 6'($urandom_range(0, 59));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
